// File: rtl/rs_gf_pkg.sv
// GF(2^8) arithmetic shared by the RS syndrome datapath: primitive polynomial
// 0x11D, alpha = 0x02, plus elaboration-time power tables for constant multipliers.
package rs_gf_pkg;

    localparam int              GF_W     = 8;
    localparam logic [GF_W:0]   GF_POLY  = 9'h11D;
    localparam int              GF_ORDER = 255;
    localparam int              MAX_PAR  = 32;

    typedef logic [GF_W-1:0] gf_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } syn_state_e;

    function automatic gf_t gf_mul(input gf_t a, input gf_t b);
        gf_t prod;
        gf_t x;
        prod = '0;
        x    = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) prod = prod ^ x;
            x = x[GF_W-1] ? ((x << 1) ^ GF_POLY[GF_W-1:0]) : (x << 1);
        end
        return prod;
    endfunction

    // alpha^n with n taken modulo the multiplicative group order.
    function automatic gf_t gf_pow(input int n);
        gf_t r;
        r = 8'h01;
        for (int i = 0; i < (n % GF_ORDER); i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    // Entry k holds alpha^((par-1-k)*root): the weight of lane k within one beat.
    function automatic logic [MAX_PAR*GF_W-1:0] gf_pow_table(input int root, input int par);
        logic [MAX_PAR*GF_W-1:0] tbl;
        tbl = '0;
        for (int k = 0; k < par; k++) tbl[GF_W*k +: GF_W] = gf_pow((par - 1 - k) * root);
        return tbl;
    endfunction

endpackage

// File: rtl/rs_syn_lane.sv
// One syndrome's Horner step: folds a beat of PAR symbols into the running
// evaluation of r(x) at alpha^(FCR+IDX) using constant GF multipliers only.
module rs_syn_lane
    import rs_gf_pkg::*;
#(
    parameter int IDX = 0,
    parameter int PAR = 16,
    parameter int FCR = 1
) (
    input  logic [GF_W-1:0]     i_acc,
    input  logic [GF_W*PAR-1:0] i_beat,
    input  logic                i_first,
    output logic [GF_W-1:0]     o_acc_next
);

    localparam int                      ROOT      = FCR + IDX;
    localparam gf_t                     ACC_COEF  = gf_pow(PAR * ROOT);
    localparam logic [MAX_PAR*GF_W-1:0] LANE_COEF = gf_pow_table(ROOT, PAR);

    logic [GF_W-1:0] w_sum;

    // NOTE: w_sum gets its value on every path before the loop folds into it,
    // so this stays purely combinational with no latch.
    always_comb begin
        w_sum = i_first ? '0 : gf_mul(i_acc, ACC_COEF);
        for (int k = 0; k < PAR; k++) begin
            w_sum = w_sum ^ gf_mul(i_beat[GF_W*k +: GF_W], LANE_COEF[GF_W*k +: GF_W]);
        end
    end

    assign o_acc_next = w_sum;

endmodule

// File: rtl/rs_syndrome_par.sv
// Parallel RS syndrome calculator: PAR symbols per beat feed NSYN Horner lanes;
// finished vectors wait in a holding register so the next codeword can stream in.
module rs_syndrome_par
    import rs_gf_pkg::*;
#(
    parameter int PAR   = 16,
    parameter int NSYN  = 32,
    parameter int N_SYM = 255,
    parameter int FCR   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic [GF_W*PAR-1:0]  in_data,
    output logic                 syn_valid,
    input  logic                 syn_ready,
    output logic [GF_W*NSYN-1:0] syn_data,
    output logic                 syn_err_free,
    output logic                 proto_err
);

    localparam int               BEATS    = (N_SYM + PAR - 1) / PAR;
    localparam int               PAD      = BEATS * PAR - N_SYM;
    localparam int               CNT_W    = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    syn_state_e           r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [GF_W*NSYN-1:0] r_acc, w_acc_next;
    logic [GF_W*NSYN-1:0] r_syn_data;
    logic [GF_W*PAR-1:0]  w_beat;
    logic                 r_syn_valid, r_err_free, r_proto_err;
    logic                 w_xfer, w_accept, w_last_pos, w_last, w_violation, w_out_xfer;

    // Shortened codes: the leading pad lanes of the sop beat are virtual zeros.
    always_comb begin
        w_beat = in_data;
        for (int k = 0; k < PAD; k++) begin
            if (in_sop) w_beat[GF_W*k +: GF_W] = '0;
        end
    end

    // Would the beat on the bus close a codeword if it were accepted now?
    always_comb begin
        if (in_sop) w_last_pos = (BEATS == 1);
        else        w_last_pos = (r_state == ST_ACCUM) && (r_cnt == CNT_LAST);
    end

    assign in_ready    = reset | ~(w_last_pos & r_syn_valid & ~syn_ready);
    assign w_xfer      = in_valid & in_ready;
    assign w_accept    = w_xfer & (in_sop | (r_state == ST_ACCUM));
    assign w_last      = w_accept & w_last_pos;
    assign w_violation = w_xfer & ((in_sop & (r_state == ST_ACCUM)) |
                                   (~in_sop & (r_state == ST_IDLE)));
    assign w_out_xfer  = r_syn_valid & syn_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_accept) begin
            w_cnt_next   = in_sop ? CNT_ONE : r_cnt + CNT_ONE;
            w_state_next = w_last ? ST_IDLE : ST_ACCUM;
        end
    end

    for (genvar i = 0; i < NSYN; i++) begin : g_lane
        rs_syn_lane #(
            .IDX (i),
            .PAR (PAR),
            .FCR (FCR)
        ) u_lane (
            .i_acc      (r_acc[GF_W*i +: GF_W]),
            .i_beat     (w_beat),
            .i_first    (in_sop),
            .o_acc_next (w_acc_next[GF_W*i +: GF_W])
        );
    end

    // NOTE: the accumulator array is reset along with the control state so a
    // reset mid-codeword leaves no partial sum behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_syn_valid <= 1'b0;
            r_syn_data  <= '0;
            r_err_free  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_proto_err <= w_violation;
            if (w_accept) r_acc <= w_acc_next;
            // A new result may land in the same cycle the old one drains.
            if (w_last) begin
                r_syn_valid <= 1'b1;
                r_syn_data  <= w_acc_next;
                r_err_free  <= ~|w_acc_next;
            end else if (w_out_xfer) begin
                r_syn_valid <= 1'b0;
                r_syn_data  <= '0;
                r_err_free  <= 1'b0;
            end
        end
    end

    assign syn_valid    = r_syn_valid;
    assign syn_data     = r_syn_data;
    assign syn_err_free = r_err_free;
    assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_rs_syndrome_par.sv
// Bench for rs_syndrome_par: random and directed codewords compared against a
// log/antilog polynomial-evaluation model, plus a PAR=4/NSYN=16/N_SYM=204 instance.
module tb_rs_syndrome_par;

    localparam int PAR     = 16;
    localparam int NSYN    = 32;
    localparam int N_SYM   = 255;
    localparam int FCR     = 1;
    localparam int BEATS   = (N_SYM + PAR - 1) / PAR;
    localparam int PAD     = BEATS * PAR - N_SYM;
    localparam int V_PAR   = 4;
    localparam int V_NSYN  = 16;
    localparam int V_NSYM  = 204;
    localparam int V_BEATS = (V_NSYM + V_PAR - 1) / V_PAR;
    localparam int V_PAD   = V_BEATS * V_PAR - V_NSYM;

    typedef logic [511:0] wide_t;
    typedef enum int {BP_READY, BP_LOW, BP_RAND} bp_e;
    typedef struct {
        logic [8*NSYN-1:0] data;
        logic              ef;
    } exp_t;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b1;
    logic                 in_valid  = 1'b0;
    logic                 in_sop    = 1'b0;
    logic [8*PAR-1:0]     in_data   = '0;
    logic                 syn_ready = 1'b1;
    logic                 in_ready, syn_valid, syn_err_free, proto_err;
    logic [8*NSYN-1:0]    syn_data;

    logic                 v_in_valid = 1'b0;
    logic                 v_in_sop   = 1'b0;
    logic [8*V_PAR-1:0]   v_in_data  = '0;
    logic                 v_in_ready, v_syn_valid, v_syn_err_free, v_proto_err;
    logic [8*V_NSYN-1:0]  v_syn_data;

    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   n_out    = 0;
    int                   n_proto  = 0;
    bp_e                  bp_mode  = BP_READY;
    exp_t                 exp_q[$];
    logic [8*NSYN-1:0]    last_syn;
    logic                 last_ef;
    logic [7:0]           cw [0:254];
    int                   gf_exp [0:254];
    int                   gf_log [0:255];

    rs_syndrome_par #(.PAR(PAR), .NSYN(NSYN), .N_SYM(N_SYM), .FCR(FCR)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sop       (in_sop),
        .in_data      (in_data),
        .syn_valid    (syn_valid),
        .syn_ready    (syn_ready),
        .syn_data     (syn_data),
        .syn_err_free (syn_err_free),
        .proto_err    (proto_err)
    );

    rs_syndrome_par #(.PAR(V_PAR), .NSYN(V_NSYN), .N_SYM(V_NSYM), .FCR(FCR)) dut_v (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (v_in_valid),
        .in_ready     (v_in_ready),
        .in_sop       (v_in_sop),
        .in_data      (v_in_data),
        .syn_valid    (v_syn_valid),
        .syn_ready    (1'b1),
        .syn_data     (v_syn_data),
        .syn_err_free (v_syn_err_free),
        .proto_err    (v_proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input wide_t got, input wide_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference field built from the polynomial itself: exp/log tables.
    function automatic void gf_init();
        int x;
        x = 1;
        for (int n = 0; n < 255; n++) begin
            gf_exp[n] = x;
            gf_log[x] = n;
            x = x << 1;
            if (x > 255) x = x ^ 'h11D;
        end
        gf_log[0] = 0;
    endfunction

    // S_i = sum over symbols of r_deg * alpha^((FCR+i)*deg); cw[0] has the top degree.
    function automatic wide_t ref_syn(input int nsym, input int nsyn);
        wide_t res;
        int    s;
        int    e;
        res = '0;
        for (int i = 0; i < nsyn; i++) begin
            s = 0;
            for (int j = 0; j < nsym; j++) begin
                if (cw[j] != 8'h00) begin
                    e = (gf_log[cw[j]] + (FCR + i) * (nsym - 1 - j)) % 255;
                    s = s ^ gf_exp[e];
                end
            end
            res[8*i +: 8] = 8'(s);
        end
        return res;
    endfunction

    function automatic void push_expected();
        wide_t r;
        exp_t  e;
        r      = ref_syn(N_SYM, NSYN);
        e.data = r[8*NSYN-1:0];
        e.ef   = (r == '0);
        exp_q.push_back(e);
    endfunction

    function automatic void fill_random();
        for (int j = 0; j < 255; j++) cw[j] = 8'($urandom_range(0, 255));
    endfunction

    function automatic void fill_zero();
        for (int j = 0; j < 255; j++) cw[j] = 8'h00;
    endfunction

    function automatic logic [8*PAR-1:0] make_beat(input int b, input bit junk_pad);
        logic [8*PAR-1:0] d;
        int               p;
        for (int k = 0; k < PAR; k++) begin
            p = b * PAR + k;
            if (p < PAD) d[8*k +: 8] = junk_pad ? 8'($urandom_range(1, 255)) : 8'h00;
            else         d[8*k +: 8] = cw[p - PAD];
        end
        return d;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_beat(input logic [8*PAR-1:0] d, input logic sop, input int gap_max,
                             inout int stalls);
        int gap;
        int waited;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            stalls++;
            waited++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) check("in_ready_timeout", wide_t'(in_ready), wide_t'(1));
        else @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_cw(input int nbeats, input bit junk_pad, input int gap_max,
                           output int stalls);
        stalls = 0;
        for (int b = 0; b < nbeats; b++) send_beat(make_beat(b, junk_pad), (b == 0), gap_max, stalls);
    endtask

    task automatic wait_out(input int target, input string tag);
        int t;
        t = 0;
        while (n_out < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(tag, wide_t'(n_out), wide_t'(target));
    endtask

    task automatic run_variant(input string tag);
        wide_t              r;
        logic [8*V_PAR-1:0] d;
        int                 p;
        r = ref_syn(V_NSYM, V_NSYN);
        for (int b = 0; b < V_BEATS; b++) begin
            for (int k = 0; k < V_PAR; k++) begin
                p = b * V_PAR + k;
                d[8*k +: 8] = (p < V_PAD) ? 8'h00 : cw[p - V_PAD];
            end
            v_in_valid = 1'b1;
            v_in_sop   = (b == 0);
            v_in_data  = d;
            #1;
            check({tag, "_in_ready"}, wide_t'(v_in_ready), wide_t'(1));
            @(posedge clk);
            @(negedge clk);
        end
        v_in_valid = 1'b0;
        v_in_sop   = 1'b0;
        #1;
        check({tag, "_valid"}, wide_t'(v_syn_valid), wide_t'(1));
        check({tag, "_data"}, wide_t'(v_syn_data), wide_t'(r[8*V_NSYN-1:0]));
        check({tag, "_err_free"}, wide_t'(v_syn_err_free), wide_t'(r == '0));
        @(negedge clk);
    endtask

    // Downstream backpressure.
    initial begin
        forever begin
            @(negedge clk);
            case (bp_mode)
                BP_READY: syn_ready = 1'b1;
                BP_LOW:   syn_ready = 1'b0;
                default:  syn_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: in-order scoreboard, hold-stability and proto_err pulse count.
    initial begin
        logic              prev_hold;
        logic [8*NSYN-1:0] prev_data;
        exp_t              e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", wide_t'(syn_valid), wide_t'(1));
                    check("hold_data", wide_t'(syn_data), wide_t'(prev_data));
                end
                if (proto_err) n_proto++;
                if (syn_valid && syn_ready) begin
                    n_out++;
                    last_syn = syn_data;
                    last_ef  = syn_err_free;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", wide_t'(syn_valid), wide_t'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("syn_data", wide_t'(syn_data), wide_t'(e.data));
                        check("syn_err_free", wide_t'(syn_err_free), wide_t'(e.ef));
                    end
                end
                prev_hold = syn_valid && !syn_ready;
                prev_data = syn_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st4 [3];
        int p0;
        int o0;
        gf_init();
        fill_zero();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_syn_valid", wide_t'(syn_valid), wide_t'(0));
        check("rst_syn_data", wide_t'(syn_data), wide_t'(0));
        check("rst_err_free", wide_t'(syn_err_free), wide_t'(0));
        check("rst_proto_err", wide_t'(proto_err), wide_t'(0));
        check("rst_in_ready", wide_t'(in_ready), wide_t'(1));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // All-zero codeword: one result, err_free, one cycle after the last beat.
        fill_zero();
        push_expected();
        send_cw(BEATS, 1'b0, 0, st);
        #1;
        check("t1_latency_valid", wide_t'(syn_valid), wide_t'(1));
        @(negedge clk);
        #1;
        check("t1_single_valid", wide_t'(syn_valid), wide_t'(0));
        wait_out(1, "t1_outputs");
        check("t1_data_zero", wide_t'(last_syn), wide_t'(0));
        check("t1_err_free", wide_t'(last_ef), wide_t'(1));

        // Single 0x01 error at degree 0.
        fill_zero();
        cw[N_SYM-1] = 8'h01;
        push_expected();
        send_cw(BEATS, 1'b0, 0, st);
        wait_out(2, "t2_outputs");
        check("t2_S0", wide_t'(last_syn[7:0]), wide_t'(8'h01));
        check("t2_Slast", wide_t'(last_syn[8*NSYN-1 -: 8]), wide_t'(8'h01));
        check("t2_err_free", wide_t'(last_ef), wide_t'(0));

        // 0x01 at degree 1, with garbage in the pad lane of the sop beat.
        fill_zero();
        cw[N_SYM-2] = 8'h01;
        push_expected();
        send_cw(BEATS, 1'b1, 0, st);
        wait_out(3, "t3_outputs");
        check("t3_S0", wide_t'(last_syn[7:0]), wide_t'(8'h02));
        check("t3_S1", wide_t'(last_syn[15:8]), wide_t'(8'h04));
        check("t3_S6", wide_t'(last_syn[55:48]), wide_t'(8'h80));
        check("t3_S7", wide_t'(last_syn[63:56]), wide_t'(8'h1D));

        // Three back-to-back codewords with the output blocked until cycle 40.
        o0 = n_out;
        bp_mode = BP_LOW;
        fork
            begin
                for (int c = 0; c < 3; c++) begin
                    fill_random();
                    push_expected();
                    send_cw(BEATS, 1'b1, 0, st4[c]);
                end
            end
            begin
                repeat (40) @(negedge clk);
                bp_mode = BP_READY;
            end
        join
        wait_out(o0 + 3, "t4_outputs");
        check("t4_cw1_stalls", wide_t'(st4[0]), wide_t'(0));
        check("t4_cw2_stalled", wide_t'(st4[1] > 0), wide_t'(1));
        check("t4_cw3_stalls", wide_t'(st4[2]), wide_t'(0));

        // Framing: sop restart after five beats, then a stray beat while idle.
        p0 = n_proto;
        o0 = n_out;
        fill_random();
        send_cw(5, 1'b1, 0, st);
        fill_random();
        push_expected();
        send_cw(BEATS, 1'b1, 0, st);
        send_beat(make_beat(3, 1'b0), 1'b0, 0, st);
        repeat (4) @(negedge clk);
        wait_out(o0 + 1, "t5_outputs");
        check("t5_proto_pulses", wide_t'(n_proto - p0), wide_t'(2));

        // Reset with a result pending and a codeword half-way in.
        o0 = n_out;
        bp_mode = BP_LOW;
        fill_random();
        send_cw(BEATS, 1'b1, 0, st);
        fill_random();
        send_cw(8, 1'b1, 0, st);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t6_rst_valid", wide_t'(syn_valid), wide_t'(0));
        check("t6_rst_data", wide_t'(syn_data), wide_t'(0));
        check("t6_rst_in_ready", wide_t'(in_ready), wide_t'(1));
        @(negedge clk);
        reset = 1'b0;
        bp_mode = BP_READY;
        repeat (5) @(negedge clk);
        #1;
        check("t6_no_stale_valid", wide_t'(syn_valid), wide_t'(0));
        @(negedge clk);
        fill_random();
        push_expected();
        send_cw(BEATS, 1'b1, 1, st);
        wait_out(o0 + 1, "t6_outputs");

        // Random codewords with input gaps and random backpressure.
        o0 = n_out;
        bp_mode = BP_RAND;
        for (int c = 0; c < 4; c++) begin
            fill_random();
            if (c == 2) cw[$urandom_range(0, N_SYM-1)] = 8'h00;
            push_expected();
            send_cw(BEATS, 1'b1, 2, st);
        end
        bp_mode = BP_READY;
        wait_out(o0 + 4, "t7_outputs");

        // Smaller configuration.
        fill_random();
        run_variant("v_rand");
        fill_zero();
        cw[V_NSYM-3] = 8'h5A;
        run_variant("v_deg2");

        repeat (5) @(negedge clk);
        check("exp_queue_empty", wide_t'(exp_q.size()), wide_t'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_par.md
Name: rs_syndrome_par

Overview:
- Parametrised RS syndrome calculator over GF(2^8), primitive poly 0x11D.
- Consumes a codeword PAR symbols per beat on a valid/ready stream and computes NSYN syndromes S_i = r(alpha^(FCR+i)), i=0..NSYN-1, by per-syndrome Horner accumulation.
- Results are handed to the key-equation solver through an output holding register, so the next codeword can stream in while the previous result waits.
- Successor to the fixed 16-lane/32-syndrome generator: adds shortened codes, framing, backpressure and an error-free flag.

Parameters:
PAR, 16, symbols per input beat (1..32)
NSYN, 32, number of syndromes (2t), even, 2..64
N_SYM, 255, codeword length in symbols (NSYN < N_SYM <= 255)
FCR, 1, exponent of first consecutive root

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
in_sop  in  1  first beat of codeword
in_data  in  8*PAR  symbols; lane 0 (bits 7:0) = highest-degree symbol of the beat
syn_valid  out  1  syndrome vector valid
syn_ready  in  1  downstream accepts syndromes
syn_data  out  8*NSYN  S_0 in bits 7:0 … S_(NSYN-1) in top byte
syn_err_free  out  1  all syndromes zero; qualified by syn_valid
proto_err  out  1  one-cycle pulse on framing violation

Behaviour:
- BEATS = ceil(N_SYM/PAR); PAD = BEATS*PAR - N_SYM. On the sop beat, lanes 0..PAD-1 are forced to zero (leading-zero shortening).
- Beat transfer = in_valid & in_ready. Output transfer = syn_valid & syn_ready.
- Per beat, each syndrome updates: acc_i <= acc_i*a^(PAR*(FCR+i)) XOR sum_k r_k*a^((PAR-1-k)*(FCR+i)).
  - All multipliers are constant GF multipliers, so the update is single-cycle.
  - The sop beat uses acc_i = 0 as its previous value.
- FSM:
  - IDLE: sop transfer → load accumulators, beat_cnt=1 → ACCUM. If BEATS==1, the sop beat is also the last beat.
  - ACCUM: each transfer increments beat_cnt. The transfer with beat_cnt==BEATS-1 is the last beat → IDLE.
- Last beat:
  - Updated accumulator values are copied into the output register, syn_valid=1 the next cycle (latency 1 cycle from last-beat transfer).
  - syn_err_free = NOR of all output bytes, registered with the data.
- Output register holds data stable while syn_valid & !syn_ready. It clears when the output transfer completes, unless a new last beat loads it in the same cycle; simultaneous drain and reload keeps syn_valid=1 with new data.
- in_ready = 0 only when the current beat would be a last beat and the output register is full and syn_ready=0. Otherwise in_ready=1; non-last beats are never stalled.
- Back-to-back codewords sustain one beat per cycle with syn_ready held high.
- Framing violations (each pulses proto_err for one cycle):
  - sop transfer in ACCUM: abort the current codeword (discarded, no output), restart with this beat.
  - non-sop transfer in IDLE: beat discarded.
- Reset:
  - Outputs: syn_valid=0, syn_data=0, syn_err_free=0, proto_err=0, in_ready=1.
  - State: IDLE, beat_cnt=0, accumulators=0.
  - Reset mid-codeword discards the partial codeword and any pending output.
- beat_cnt width clog2(BEATS+1). No wrap: it is reloaded on every sop.

Decomposition:
- Package rs_gf_pkg:
  - GF_W=8, GF_POLY=0x11D.
  - gf_mul function; gf_pow (alpha^n, n mod 255) function.
  - Elaboration-time constant-table generation for alpha^(k*(FCR+i)).
- Sub-module rs_syn_lane: one syndrome's Horner update.
  - Combinational, parameters IDX, PAR, FCR.
  - Inputs: acc, beat data, first flag. Output: next acc.
  - Instantiated NSYN times by generate.
- FSM, pad mask, counter and output register live in rs_syndrome_par.

Test Plan:
- All-zero codeword, defaults (16 beats) → one syn_valid, syn_data all 0x00, syn_err_free=1, latency 1 cycle after beat 16.
- Single error 0x01 at degree 0 (lane 15 of last beat) → every S_i=0x01, err_free=0.
- Error 0x01 at degree 1 → S_i=alpha^(1+i): S_0=0x02, S_1=0x04, S_6=0x80, S_7=0x1D; nonzero data in pad lane 0 of sop beat is ignored.
- Three back-to-back codewords with syn_ready low until cycle 40:
  - first result held stable;
  - second codeword's last beat sees in_ready=0 until the drain;
  - third codeword streams without gaps after the drain;
  - results come out in order.
- sop asserted at beat 5, then a non-sop beat while IDLE → proto_err pulses twice, only the restarted codeword produces output.
- reset asserted at beat 8, then a fresh codeword → no stale syn_valid; correct syndromes for the new codeword; PAR=4/NSYN=16/N_SYM=204 variant gives matching software-model results.
